line_buffer_3row: RTL
=====================

Name: line_buffer_3row

Overview:
Row-tap generator that feeds 3x3 window stages such as the Laplacian matrix. It takes a single raster pixel stream and stores the previous two lines in on-chip RAM. Each accepted pixel produces three vertically aligned column taps on dout1/dout2/dout3 (rows y-2, y-1, y) plus a valid strobe. This is the producer side of the din1/din2/din3 + valid_in interface that window stages consume.

Parameters:
WIDTH, 24, pixel width in bits (RGB888 or replicated gray)
PIC_WIDTH, 480, pixels per line; must be <= 512
PIC_HEIGHT, 272, lines per frame; must be <= 512

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
valid_in  input  1  din carries a pixel this cycle
sof  input  1  start of frame; qualified by valid_in, marks pixel (0,0)
din  input  WIDTH  incoming pixel, raster order
valid_out  output  1  dout1..3 hold a valid column triple
dout1  output  WIDTH  pixel at (row-2, col), oldest line
dout2  output  WIDTH  pixel at (row-1, col)
dout3  output  WIDTH  pixel at (row, col), current line
eol_out  output  1  aligned with valid_out; last column of a line
eof_out  output  1  aligned with valid_out; last pixel of the frame

Behaviour:
- Reset (async assert, sync release): col_cnt=0, row_cnt=0; valid_out, eol_out, eof_out = 0; dout1..3 = 0. RAM contents are not cleared. Stale data never reaches the outputs because of row gating.
- Storage: two line RAMs, L0 and L1, each PIC_WIDTH x WIDTH, addressed by col_cnt (9 bits).
  - L0 holds line y-1. L1 holds line y-2.
- On a cycle with valid_in=1, at address a = col_cnt:
  - Read L0[a] and L1[a] (old values).
  - Write L0[a] <= din and L1[a] <= old L0[a].
  - The read must return pre-write data (read-before-write), or an equivalent bypass.
- Latency: exactly 1 clk from the accepted pixel to registered outputs.
  - dout3 = din, dout2 = old L0[a], dout1 = old L1[a].
- Counters:
  - col_cnt increments on each accepted pixel and wraps from PIC_WIDTH-1 to 0.
  - On that wrap, row_cnt increments, wrapping from PIC_HEIGHT-1 to 0.
- sof=1 with valid_in=1: the pixel is treated as col 0, row 0 regardless of counter state.
  - Counters become col=1, row=0 (or col=0, row=1 when PIC_WIDTH=1).
  - This resynchronises a misaligned stream. sof without valid_in is ignored.
- valid_out = registered (valid_in && row>=2) for the accepted pixel.
  - Rows 0 and 1 only prime the buffers and never raise valid_out.
- eol_out: set with valid_out when the accepted pixel had col = PIC_WIDTH-1.
- eof_out: additionally requires row = PIC_HEIGHT-1.
- valid_in=0 (stall):
  - No RAM write, counters hold, dout1..3 hold.
  - valid_out, eol_out, eof_out = 0 on the next cycle.
  - Stalls may occur at any pixel, including mid-line and on wrap pixels.
- Frame wrap: after the eof pixel, the next frame's rows 0 and 1 are priming rows again. No valid_out for those rows, even though the RAMs hold previous-frame data.
- Reset mid-frame: outputs clear immediately, and the next accepted pixel is (0,0). The downstream window stage must be reset together with this block.
- Throughput: one pixel per clk sustained; no backpressure input.

Test Plan:
- Params PIC_WIDTH=4, PIC_HEIGHT=4, WIDTH=24, din = {16'h0, row, col} as nibbles. Stream a full frame with no stalls.
  - Rows 0-1 -> valid_out stays 0.
  - Pixel (2,1) -> one clk later valid_out=1, dout1=0x01, dout2=0x11, dout3=0x21.
  - Pixel (3,3) -> dout1=0x13, dout2=0x23, dout3=0x33, eol_out=1, eof_out=1.
- Random valid_in gaps (about 40%) in row 2 -> the same triples as the no-stall run.
  - valid_out low on every gap cycle; douts hold their last values during gaps.
- Back-to-back frames -> eof_out pulses once per frame.
  - Second frame rows 0-1 produce no valid_out.
  - Second frame pixel (2,0) -> dout1=0x00, dout2=0x10, dout3=0x20 (new frame data).
- sof asserted on the third pixel of row 1 -> that pixel becomes (0,0).
  - The first valid_out follows 8 further accepted pixels later, at row 2 col 0 of the new alignment.
- rst_n pulled low mid-row 2 -> valid_out=0 and douts=0 asynchronously.
  - A subsequent full frame behaves exactly as in the first scenario.
- PIC_WIDTH=480 full line sweep -> col wrap at 479 sets eol_out.
  - dout2 equals the value written 480 accepted pixels earlier; address never exceeds 479.

Source files
------------

// File: rtl/line_buffer_3row_if.sv
// Pixel-stream bundle between a raster source, the row-tap generator
// and the 3x3 window stage that consumes its column triples.
interface line_buffer_3row_if #(
    parameter int WIDTH = 24
);
    logic             valid_in;
    logic             sof;
    logic [WIDTH-1:0] din;
    logic             valid_out;
    logic [WIDTH-1:0] dout1;
    logic [WIDTH-1:0] dout2;
    logic [WIDTH-1:0] dout3;
    logic             eol_out;
    logic             eof_out;

    modport master (
        output valid_in, sof, din,
        input  valid_out, dout1, dout2, dout3, eol_out, eof_out
    );

    modport slave (
        input  valid_in, sof, din,
        output valid_out, dout1, dout2, dout3, eol_out, eof_out
    );
endinterface

// File: rtl/line_buffer_3row.sv
// Two-line RAM row-tap generator: emits (y-2, y-1, y) column triples
// one cycle after each accepted raster pixel.
module line_buffer_3row #(
    parameter int WIDTH      = 24,
    parameter int PIC_WIDTH  = 480,
    parameter int PIC_HEIGHT = 272
) (
    input logic               clk,
    input logic               rst_n,
    line_buffer_3row_if.slave s
);
    localparam int AW = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;
    localparam logic [8:0] LAST_COL = 9'(PIC_WIDTH - 1);
    localparam logic [8:0] LAST_ROW = 9'(PIC_HEIGHT - 1);

    logic [WIDTH-1:0] l0 [PIC_WIDTH];
    logic [WIDTH-1:0] l1 [PIC_WIDTH];

    logic [8:0]    col_cnt;
    logic [8:0]    row_cnt;
    logic [8:0]    col_e;
    logic [8:0]    row_e;
    logic [8:0]    col_nx;
    logic [8:0]    row_nx;
    logic          last_col;
    logic          last_row;
    logic          live;
    logic [AW-1:0] addr;

    // sof forces the accepted pixel to (0,0) whatever the counters say
    always_comb begin
        col_e    = s.sof ? 9'd0 : col_cnt;
        row_e    = s.sof ? 9'd0 : row_cnt;
        last_col = (col_e == LAST_COL);
        last_row = (row_e == LAST_ROW);
        live     = (row_e >= 9'd2);
        addr     = col_e[AW-1:0];
        col_nx   = last_col ? 9'd0 : col_e + 9'd1;
        row_nx   = row_e;
        if (last_col)
            row_nx = last_row ? 9'd0 : row_e + 9'd1;
    end

    // read-before-write: the shift L0 -> L1 uses the old L0 word
    always_ff @(posedge clk) begin
        if (s.valid_in) begin
            l0[addr] <= s.din;
            l1[addr] <= l0[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt     <= '0;
            row_cnt     <= '0;
            s.valid_out <= 1'b0;
            s.eol_out   <= 1'b0;
            s.eof_out   <= 1'b0;
            s.dout1     <= '0;
            s.dout2     <= '0;
            s.dout3     <= '0;
        end else begin
            s.valid_out <= s.valid_in && live;
            s.eol_out   <= s.valid_in && live && last_col;
            s.eof_out   <= s.valid_in && live && last_col && last_row;
            if (s.valid_in) begin
                col_cnt <= col_nx;
                row_cnt <= row_nx;
                s.dout3 <= s.din;
                s.dout2 <= l0[addr];
                s.dout1 <= l1[addr];
            end
        end
    end
endmodule
